spi_fetch_unit: RTL
===================

SPI_FETCH_UNIT -- requirements
Module: spi_fetch_unit

Interface
REQ-001 The block SHALL have parameter WORD_BYTES, default 2, giving the bytes per fetched word; legal range 1..4.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port fetch_req, input, 1, request to fetch one word; sampled only in IDLE.
REQ-005 The block SHALL have port fetch_addr, input, 16, byte address of the word's first byte; sampled with fetch_req.
REQ-006 The block SHALL have port flush, input, 1, cancels any fetch in progress.
REQ-007 The block SHALL have port fetch_busy, output, 1, high in every state except IDLE.
REQ-008 The block SHALL have port fetch_valid, output, 1, one-cycle pulse when instr holds a completed word.
REQ-009 The block SHALL have port instr, output, 8*WORD_BYTES, assembled word; big-endian, byte at fetch_addr in the MSB.
REQ-010 The block SHALL have port rd_start, output, 1, one-cycle start pulse to the SPI byte reader.
REQ-011 The block SHALL have port rd_addr, output, 16, byte address presented to the SPI byte reader.
REQ-012 The block SHALL have port rd_busy, input, 1, SPI byte reader is busy.
REQ-013 The block SHALL have port rd_done, input, 1, one-cycle pulse from the reader; rd_data is valid in the same cycle.
REQ-014 The block SHALL have port rd_data, input, 8, byte returned by the reader.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, WAIT, DRAIN and DONE.
REQ-016 IDLE with fetch_req=1 and flush=0: the block SHALL latch fetch_addr as base, clear byte index idx to 0, and go to ISSUE.
REQ-017 ISSUE with rd_busy=0: the block SHALL assert rd_start for exactly one cycle with rd_addr = base+idx (16-bit, wraps 0xFFFF->0x0000), then go to WAIT.
REQ-018 ISSUE with rd_busy=1: the block SHALL remain in ISSUE with rd_start low.
REQ-019 rd_addr SHALL hold the address of the last issued byte from ISSUE through WAIT.
REQ-020 WAIT with rd_done=1: the block SHALL store rd_data into byte slot idx (idx 0 into the MSB).
REQ-021 After storing, if idx = WORD_BYTES-1 the block SHALL go to DONE; otherwise it SHALL increment idx and go to ISSUE.
REQ-022 DONE: the block SHALL assert fetch_valid for one cycle, then go to IDLE.
REQ-023 instr SHALL hold its value until the next fetch updates its first byte slot.
REQ-024 Fetch latency SHALL be WORD_BYTES x (reader latency + 1 cycle), plus 1 cycle for DONE.
REQ-025 fetch_req outside IDLE SHALL be ignored; the block SHALL NOT queue it.
REQ-026 Flush in IDLE SHALL win over a simultaneous fetch_req; the request is dropped.
REQ-027 Flush in ISSUE SHALL move the block to IDLE with no rd_start issued in that cycle.
REQ-028 Flush in WAIT without rd_done SHALL move the block to DRAIN.
REQ-029 DRAIN SHALL wait for rd_done, discard rd_data, then go to IDLE; fetch_busy stays high throughout.
REQ-030 Flush in WAIT together with rd_done SHALL discard the byte and move the block to IDLE.
REQ-031 Flush in DONE SHALL suppress fetch_valid and move the block to IDLE.
REQ-032 The block SHALL never issue rd_start while a previously started read is outstanding.

Reset
REQ-033 On rst=1 at a clock edge the block SHALL go to IDLE with idx=0, base=0, fetch_busy=0, fetch_valid=0, rd_start=0, rd_addr=0, and instr=0.
REQ-034 Reset SHALL take priority over every other input, including in mid-fetch states.
REQ-035 An outstanding reader transfer interrupted by reset SHALL be the reader's own concern; after reset the block SHALL ignore rd_done until its next own rd_start.

Verification
REQ-036 RAM[0x0012]=0xA5, RAM[0x0013]=0x3C, fetch 0x0012 -> rd_start at 0x0012 then 0x0013; instr=0xA53C; one fetch_valid pulse.
REQ-037 WORD_BYTES=2, fetch 0xFFFF, RAM[0xFFFF]=0x11, RAM[0x0000]=0x22 -> second rd_addr=0x0000; instr=0x1122.
REQ-038 Flush during WAIT of byte 0 -> DRAIN until rd_done; no fetch_valid; instr unchanged; next fetch at 0x0012 returns 0xA53C.
REQ-039 rd_busy held high 5 cycles while in ISSUE -> rd_start is delayed exactly until the cycle rd_busy falls.
REQ-040 fetch_req pulsed while fetch_busy=1 -> ignored; exactly WORD_BYTES rd_start pulses are seen per accepted fetch.
REQ-041 rst pulsed during WAIT of byte 1 -> all outputs 0 next cycle; a subsequent fetch completes correctly.

Source files
------------

// File: rtl/spi_fetch_unit.sv
// spi_fetch_unit: assembles a big-endian word of WORD_BYTES bytes, one SPI byte read at a time,
// with flush handling that never abandons an outstanding reader transfer mid-flight.
module spi_fetch_unit #(
    parameter int WORD_BYTES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_req,
    input  logic [15:0]             fetch_addr,
    input  logic                    flush,
    output logic                    fetch_busy,
    output logic                    fetch_valid,
    output logic [8*WORD_BYTES-1:0] instr,
    output logic                    rd_start,
    output logic [15:0]             rd_addr,
    input  logic                    rd_busy,
    input  logic                    rd_done,
    input  logic [7:0]              rd_data
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [15:0]             base_q, base_d;
    logic [15:0]             rd_addr_q, rd_addr_d;
    logic [1:0]              idx_q, idx_d;
    logic [8*WORD_BYTES-1:0] instr_q, instr_d;
    logic                    accept, last, store;

    assign accept = (state_q == IDLE) && fetch_req && !flush;
    assign last   = idx_q == 2'(WORD_BYTES - 1);
    assign store  = (state_q == WAIT) && rd_done && !flush;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? ISSUE : IDLE;
            ISSUE:   state_d = flush ? IDLE : (rd_busy ? ISSUE : WAIT);
            WAIT:    state_d = rd_done ? (flush ? IDLE : (last ? DONE : ISSUE)) : (flush ? DRAIN : WAIT);
            DRAIN:   state_d = rd_done ? IDLE : DRAIN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_busy  = state_q != IDLE;
        fetch_valid = (state_q == DONE) && !flush;
        rd_start    = (state_q == ISSUE) && !rd_busy && !flush;
    end

    // rd_addr is loaded ahead of ISSUE so it already shows base+idx when rd_start fires
    always_comb begin
        base_d    = accept ? fetch_addr : base_q;
        idx_d     = accept ? 2'd0 : ((store && !last) ? idx_q + 2'd1 : idx_q);
        rd_addr_d = accept ? fetch_addr : ((store && !last) ? base_q + 16'(idx_q) + 16'd1 : rd_addr_q);
        instr_d   = instr_q;
        for (int i = 0; i < WORD_BYTES; i++)
            if (store && idx_q == 2'(i)) instr_d[8*(WORD_BYTES-1-i) +: 8] = rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            idx_q     <= '0;
            rd_addr_q <= '0;
            instr_q   <= '0;
        end else begin
            base_q    <= base_d;
            idx_q     <= idx_d;
            rd_addr_q <= rd_addr_d;
            instr_q   <= instr_d;
        end
    end

    assign rd_addr = rd_addr_q;
    assign instr   = instr_q;
endmodule
